cabac_bitstream_reader: RTL and testbench
=========================================

# cabac_bitstream_reader

- Byte-to-bit front end for the CABAC arithmetic decoder. Sits directly upstream of `Decoder`.
- Accepts slice-data bytes on a valid/ready stream and strips emulation-prevention bytes (00 00 03 → 00 00).
- Buffers the payload MSB-first and serves 1..MAX_REQ bits per request, for decoder init, renormalisation shifts and bypass bins.
- `flush` restarts it at every slice boundary.

## Interface
- `BUF_W`, default 32: bit-buffer width; must be ≥ MAX_REQ+8.
- `MAX_REQ`, default 16: maximum bits per request; decoder init takes 16.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; clears all state.
- `flush` input 1: synchronous clear of buffer, count and zero-run; wins over every same-cycle event.
- `byte_in` input 8: payload byte.
- `byte_valid` input 1: `byte_in` is valid.
- `byte_ready` output 1: reader takes the byte this cycle.
- `req_valid` input 1: decoder requests bits.
- `req_nbits` input 5: number of bits requested, 1..MAX_REQ; 0 is illegal.
- `req_ready` output 1: request granted this cycle.
- `bits_out` output MAX_REQ: requested bits, right-aligned, first stream bit in position `req_nbits-1`; upper bits zero.
- `bits_avail` output 6: current buffered bit count.
- `epb_drop` output 1: one-cycle pulse when an EPB is discarded.

## Operation
- Buffer `buf[BUF_W-1:0]` is MSB-aligned: `buf[BUF_W-1]` is the next stream bit. `count` holds 0..BUF_W valid bits.
- **Byte accept:** `byte_ready = !flush && (count <= BUF_W-8)`, using the current count only, not same-cycle consumption. A transfer is `byte_valid && byte_ready`.
- **EPB filter:** 2-bit saturating `zero_run` is updated on each transferred byte.
  - 0x00: `zero_run` increments, saturating at 2.
  - 0x03 with `zero_run==2`: byte is discarded (not loaded), `zero_run`←0, `epb_drop` pulses next cycle.
  - Any other byte: `zero_run`←0.
  - A discarded EPB is still handshaked, so `byte_ready` does not depend on the byte value.
- **Request:**
  - `req_ready = !flush && req_valid && (count >= req_nbits)`.
  - `bits_out` is combinational: `buf[BUF_W-1 -: req_nbits]`, zero-extended.
  - On a grant, `buf` shifts left by `req_nbits` and `count -= req_nbits`.
- **Simultaneous grant and load:**
  - `count_next = count - n + 8`.
  - The new byte is written at bits `[BUF_W-1-(count-n) -: 8]` of the shifted buffer.
  - Bits below `count_next` are don't-care; the implementation zeroes them.
- **Underflow:** a request larger than `count` stalls with `req_ready=0`; the buffer is unchanged. The decoder holds `req_valid`/`req_nbits` stable until granted.
- **Simultaneous flush:** `flush` with `byte_valid` or `req_valid` drops both. Nothing is granted, and `count`, `buf` and `zero_run` are 0 next cycle.

## Timing
- **Reset values:** `byte_ready`=1, `req_ready`=0, `bits_out`=0, `bits_avail`=0, `epb_drop`=0, `zero_run`=0.
- **Grant latency:** same-cycle combinational grant. `bits_out` is valid while `req_ready=1` and is sampled by the decoder at that clock edge.
- **Byte-to-visibility latency:** a byte accepted at edge k is visible to requests in cycle k+1. There is no bypass from `byte_in` to `bits_out`.
- **Throughput:** 1 byte in and 1 request out per cycle, sustained, for `req_nbits` ≤ 8.
- `bits_avail` is a register and reflects post-edge state.
- **Reset mid-operation:** asserting `reset` clears the outputs immediately (asynchronously). The first accept is possible on the first edge after deassertion.

## Structure
- **Package `cabac_pkg`:**
  - `BUF_W` and `MAX_REQ` defaults.
  - `EPB_BYTE` = 8'h03.
  - `ZERO_RUN_EPB` = 2.
  - Request-width typedef `nbits_t` (5-bit).
- **Sub-module `epb_filter`:**
  - Holds the zero-run counter.
  - Inputs: byte, transfer strobe, flush.
  - Outputs: `keep` and `epb_drop`.
- The shifter/counter datapath stays in the top module.

## Test plan
- **Init read:** push bytes A5 3C, request 16 → `bits_out`=16'hA53C, `bits_avail` 16→0.
- **EPB strip:** push 00 00 03 01, request 8 ×3 → 00, 00, 01. `epb_drop` pulses exactly once, and `bits_avail` never exceeds 24.
- **Non-EPB patterns:**
  - 00 03 (single zero) → 03 is kept.
  - 00 00 00 03 → 03 is dropped.
  - 00 00 03 00 00 03 → both 03 bytes are dropped.
- **Variable shifts plus simultaneous load:**
  - Stream F0 0F, request 3,5,1,7 → 111, 10000, 0, 0001111.
  - Concurrently feed 1 byte per cycle; verify `count_next` = count − n + 8 every cycle.
- **Underflow stall:** `bits_avail`=4, request 6 → `req_ready`=0 held. Push 1 byte → grant next cycle with the correct 6 bits.
- **Full buffer:** fill to 32 with no requests → `byte_ready`=0 at count 32. Request 8 → `byte_ready` returns to 1 the next cycle.
- **Flush and reset:**
  - `flush` during a concurrent grant and byte → no grant, and `count`=0 next cycle.
  - Asynchronous `reset` mid-stream → outputs at reset values before the next edge.

Source files
------------

// File: rtl/cabac_pkg.sv
// Shared constants and types for the CABAC bitstream front end.
package cabac_pkg;

  localparam int BUF_W_DEFAULT   = 32;
  localparam int MAX_REQ_DEFAULT = 16;

  // Emulation-prevention byte and the zero run that arms its removal.
  localparam logic [7:0] EPB_BYTE     = 8'h03;
  localparam logic [1:0] ZERO_RUN_EPB = 2'd2;

  typedef logic [4:0] nbits_t;

endpackage

// File: rtl/cabac_bitstream_reader_epb_filter.sv
// Emulation-prevention filter: tracks the run of 0x00 bytes and flags the
// 0x03 that follows two zeros so the caller can discard it.
module epb_filter
  import cabac_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       xfer_i,
  input  logic [7:0] byte_i,
  output logic       keep_o,
  output logic       epb_drop_o
);

  logic [1:0] zero_run_q, zero_run_d;
  logic       epb_drop_q, epb_drop_d;

  // Classify the presented byte and compute the next zero-run / drop pulse.
  always_comb begin
    keep_o     = 1'b1;
    zero_run_d = zero_run_q;
    epb_drop_d = 1'b0;
    if ((byte_i == EPB_BYTE) && (zero_run_q == ZERO_RUN_EPB)) begin
      keep_o = 1'b0;
    end else begin
      keep_o = 1'b1;
    end
    if (flush_i) begin
      zero_run_d = 2'd0;
    end else if (xfer_i) begin
      if (!keep_o) begin
        zero_run_d = 2'd0;
        epb_drop_d = 1'b1;
      end else if (byte_i == 8'h00) begin
        if (zero_run_q == ZERO_RUN_EPB) begin
          zero_run_d = zero_run_q;
        end else begin
          zero_run_d = zero_run_q + 2'd1;
        end
      end else begin
        zero_run_d = 2'd0;
      end
    end else begin
      zero_run_d = zero_run_q;
    end
  end

  // Zero-run counter and drop pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zero_run_q <= 2'd0;
      epb_drop_q <= 1'b0;
    end else begin
      zero_run_q <= zero_run_d;
      epb_drop_q <= epb_drop_d;
    end
  end

  assign epb_drop_o = epb_drop_q;

endmodule

// File: rtl/cabac_bitstream_reader.sv
// Byte-to-bit front end for the CABAC arithmetic decoder: accepts bytes,
// strips emulation-prevention bytes and serves MSB-first bit requests.
module cabac_bitstream_reader
  import cabac_pkg::*;
#(
  parameter int BUF_W   = BUF_W_DEFAULT,
  parameter int MAX_REQ = MAX_REQ_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  input  logic               req_valid,
  input  logic [4:0]         req_nbits,
  output logic               req_ready,
  output logic [MAX_REQ-1:0] bits_out,
  output logic [5:0]         bits_avail,
  output logic               epb_drop
);

  localparam logic [5:0] LOAD_LIMIT = 6'(BUF_W - 8);
  localparam logic [5:0] BUF_W_C    = 6'(BUF_W);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0] shifted_s, ins_s;
  logic [5:0]       count_q, count_d;
  logic [5:0]       remain_s, nb_s;
  logic             xfer_s, keep_s, load_s, grant_s;

  assign nb_s       = {1'b0, req_nbits};
  // Acceptance looks only at the current fill, never at same-cycle consumption.
  assign byte_ready = !flush && (count_q <= LOAD_LIMIT);
  assign xfer_s     = byte_valid && byte_ready;
  assign grant_s    = !flush && req_valid && (count_q >= nb_s);
  assign req_ready  = grant_s;
  assign load_s     = xfer_s && keep_s;
  // Top req_nbits bits of the buffer, right-aligned; a shift of BUF_W yields zero.
  assign bits_out   = MAX_REQ'(buf_q >> (BUF_W_C - nb_s));
  assign bits_avail = count_q;

  epb_filter u_epb_filter (
    .clk_i      (clk),
    .rst_i      (reset),
    .flush_i    (flush),
    .xfer_i     (xfer_s),
    .byte_i     (byte_in),
    .keep_o     (keep_s),
    .epb_drop_o (epb_drop)
  );

  // Consume granted bits, then append a kept byte right after the remaining ones.
  always_comb begin
    shifted_s = buf_q;
    remain_s  = count_q;
    if (grant_s) begin
      shifted_s = buf_q << nb_s;
      remain_s  = count_q - nb_s;
    end else begin
      shifted_s = buf_q;
      remain_s  = count_q;
    end
    // Bits below the valid count are always zero, so OR-ing the byte in is safe.
    ins_s   = {byte_in, {(BUF_W-8){1'b0}}} >> remain_s;
    buf_d   = shifted_s;
    count_d = remain_s;
    if (flush) begin
      buf_d   = {BUF_W{1'b0}};
      count_d = 6'd0;
    end else if (load_s) begin
      buf_d   = shifted_s | ins_s;
      count_d = remain_s + 6'd8;
    end else begin
      buf_d   = shifted_s;
      count_d = remain_s;
    end
  end

  // Bit buffer and fill count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= {BUF_W{1'b0}};
      count_q <= 6'd0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_cabac_bitstream_reader.sv
// Self-checking bench: bit-queue reference model plus directed literal checks
// and a randomized stream phase.
module tb_cabac_bitstream_reader;

  logic        clk = 1'b0;
  logic        reset, flush, byte_valid, req_valid;
  logic [7:0]  byte_in;
  logic [4:0]  req_nbits;
  logic        byte_ready, req_ready, epb_drop;
  logic [15:0] bits_out;
  logic [5:0]  bits_avail;

  int tests = 0;
  int fails = 0;

  // Reference model: payload bits in stream order, zero run, pending drop pulse.
  bit mq[$];
  int zr = 0;
  bit dexp = 1'b0;
  bit e_br, e_rr;
  bit m_f, m_bv, m_rv;
  logic [7:0] m_bi;
  int m_rn;

  always #5 clk = ~clk;

  cabac_bitstream_reader dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .req_valid  (req_valid),
    .req_nbits  (req_nbits),
    .req_ready  (req_ready),
    .bits_out   (bits_out),
    .bits_avail (bits_avail),
    .epb_drop   (epb_drop)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and compare against the model.
  task automatic drive(input bit f_i, input bit bv_i, input logic [7:0] bi_i,
                       input bit rv_i, input int rn_i);
    logic [15:0] v;
    @(negedge clk);
    m_f = f_i; m_bv = bv_i; m_bi = bi_i; m_rv = rv_i; m_rn = rn_i;
    flush = f_i; byte_valid = bv_i; byte_in = bi_i;
    req_valid = rv_i; req_nbits = 5'(rn_i);
    #1;
    e_br = !f_i && (mq.size() <= 24);
    e_rr = !f_i && rv_i && (mq.size() >= rn_i);
    chk("byte_ready", int'(byte_ready), int'(e_br));
    chk("req_ready", int'(req_ready), int'(e_rr));
    chk("bits_avail", int'(bits_avail), mq.size());
    chk("epb_drop", int'(epb_drop), int'(dexp));
    if (e_rr) begin
      v = 16'h0000;
      for (int i = 0; i < rn_i; i++) v = {v[14:0], mq[i]};
      chk("bits_out", int'(bits_out), int'(v));
    end
  endtask

  // Advance through the rising edge and apply the stream rules to the model.
  task automatic commit();
    @(posedge clk);
    if (m_f) begin
      mq.delete();
      zr = 0;
      dexp = 1'b0;
    end else begin
      if (e_rr) repeat (m_rn) void'(mq.pop_front());
      dexp = 1'b0;
      if (m_bv && e_br) begin
        if (m_bi == 8'h03 && zr == 2) begin
          dexp = 1'b1;
          zr = 0;
        end else begin
          for (int i = 7; i >= 0; i--) mq.push_back(m_bi[i]);
          zr = (m_bi == 8'h00) ? ((zr < 2) ? zr + 1 : 2) : 0;
        end
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    drive(1'b0, 1'b1, b, 1'b0, 1);
    commit();
  endtask

  task automatic req(input int n);
    drive(1'b0, 1'b0, 8'h00, 1'b1, n);
  endtask

  task automatic do_flush();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1);
    commit();
  endtask

  initial begin
    bit pend;
    int pn;
    reset = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    req_valid = 1'b0; req_nbits = 5'd1;

    // Reset values while reset is held.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1);
    chk("rst_byte_ready", int'(byte_ready), 1);
    chk("rst_bits_out", int'(bits_out), 0);
    commit();
    reset = 1'b0;

    // Init read.
    push(8'hA5);
    push(8'h3C);
    req(16);
    chk("init_avail", int'(bits_avail), 16);
    chk("init_bits", int'(bits_out), 16'hA53C);
    commit();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1);
    chk("init_avail_after", int'(bits_avail), 0);
    commit();

    // EPB strip: 00 00 03 01.
    push(8'h00); push(8'h00); push(8'h03);
    drive(1'b0, 1'b1, 8'h01, 1'b0, 1);
    chk("epb_pulse", int'(epb_drop), 1);
    chk("epb_avail16", int'(bits_avail), 16);
    commit();
    req(8); chk("epb_pulse_once", int'(epb_drop), 0);
    chk("epb_avail24", int'(bits_avail), 24);
    chk("epb_b0", int'(bits_out), 8'h00); commit();
    req(8); chk("epb_b1", int'(bits_out), 8'h00); commit();
    req(8); chk("epb_b2", int'(bits_out), 8'h01); commit();

    // 00 03: single zero keeps the 03.
    do_flush();
    push(8'h00); push(8'h03);
    req(16);
    chk("p1_drop", int'(epb_drop), 0);
    chk("p1_bits", int'(bits_out), 16'h0003);
    commit();

    // 00 00 00 03: saturated run still drops the 03.
    do_flush();
    push(8'h00); push(8'h00); push(8'h00); push(8'h03);
    req(16);
    chk("p2_drop", int'(epb_drop), 1);
    chk("p2_avail", int'(bits_avail), 24);
    commit();

    // 00 00 03 00 00 03: both dropped.
    do_flush();
    push(8'h00); push(8'h00); push(8'h03);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1);
    chk("p3_drop1", int'(epb_drop), 1);
    commit();
    drive(1'b0, 1'b1, 8'h00, 1'b1, 8); commit();
    drive(1'b0, 1'b1, 8'h03, 1'b1, 8); commit();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1);
    chk("p3_drop2", int'(epb_drop), 1);
    chk("p3_avail", int'(bits_avail), 16);
    commit();

    // Variable shifts with concurrent loads.
    do_flush();
    push(8'hF0); push(8'h0F);
    drive(1'b0, 1'b1, 8'h11, 1'b1, 3);
    chk("vs_a16", int'(bits_avail), 16); chk("vs_b3", int'(bits_out), 7); commit();
    drive(1'b0, 1'b1, 8'h22, 1'b1, 5);
    chk("vs_a21", int'(bits_avail), 21); chk("vs_b5", int'(bits_out), 16); commit();
    drive(1'b0, 1'b1, 8'h33, 1'b1, 1);
    chk("vs_a24", int'(bits_avail), 24); chk("vs_b1", int'(bits_out), 0); commit();
    drive(1'b0, 1'b1, 8'h44, 1'b1, 7);
    chk("vs_a31", int'(bits_avail), 31); chk("vs_br", int'(byte_ready), 0);
    chk("vs_b7", int'(bits_out), 15); commit();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1);
    chk("vs_a24b", int'(bits_avail), 24); commit();

    // Underflow stall.
    do_flush();
    push(8'hF0);
    req(4); chk("uf_b4", int'(bits_out), 15); commit();
    req(6); chk("uf_stall", int'(req_ready), 0); chk("uf_a4", int'(bits_avail), 4); commit();
    drive(1'b0, 1'b1, 8'hAB, 1'b1, 6); chk("uf_stall2", int'(req_ready), 0); commit();
    req(6); chk("uf_grant", int'(req_ready), 1); chk("uf_b6", int'(bits_out), 2);
    chk("uf_a12", int'(bits_avail), 12); commit();

    // Full buffer.
    do_flush();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1);
    chk("full_br", int'(byte_ready), 0); chk("full_a32", int'(bits_avail), 32); commit();
    drive(1'b0, 1'b1, 8'h55, 1'b1, 8);
    chk("full_br2", int'(byte_ready), 0); chk("full_b8", int'(bits_out), 8'h11); commit();
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1);
    chk("full_br_back", int'(byte_ready), 1); chk("full_a24", int'(bits_avail), 24); commit();

    // Flush during concurrent grant and byte.
    drive(1'b1, 1'b1, 8'h66, 1'b1, 8);
    chk("fl_rr", int'(req_ready), 0); chk("fl_br", int'(byte_ready), 0); commit();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1);
    chk("fl_a0", int'(bits_avail), 0); commit();

    // Asynchronous reset mid-stream.
    push(8'h00); push(8'h00); push(8'h03);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8);
    chk("ar_pre_drop", int'(epb_drop), 1);
    chk("ar_pre_avail", int'(bits_avail), 16);
    reset = 1'b1;
    #1;
    chk("ar_byte_ready", int'(byte_ready), 1);
    chk("ar_req_ready", int'(req_ready), 0);
    chk("ar_bits_out", int'(bits_out), 0);
    chk("ar_bits_avail", int'(bits_avail), 0);
    chk("ar_epb_drop", int'(epb_drop), 0);
    mq.delete(); zr = 0; dexp = 1'b0; e_rr = 1'b0; e_br = 1'b0;
    m_bv = 1'b0; m_rv = 1'b0; m_f = 1'b0;
    reset = 1'b0;
    commit();
    // Zero run must also be cleared: 00 00 then 03 after reset keeps the 03? No:
    // run restarts at zero, so 00 03 keeps it.
    push(8'h00); push(8'h03);
    req(16); chk("ar_zr", int'(bits_out), 16'h0003); commit();

    // Randomized stream; a stalled request is held until granted.
    pend = 1'b0;
    pn = 1;
    for (int c = 0; c < 3000; c++) begin
      bit f;
      bit bv;
      logic [7:0] bi;
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1'b1;
        pn = $urandom_range(1, 16);
      end
      f = ($urandom_range(0, 49) == 0);
      bv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: bi = 8'h00;
        1: bi = 8'h03;
        default: bi = 8'($urandom_range(0, 255));
      endcase
      drive(f, bv, bi, pend, pn);
      commit();
      if (e_rr) pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
